tile_grid_renderer: RTL and testbench

- Parametrised pixel-pipeline successor to the fixed 32x32 tile board drawing in the game top level.
- Maps the current VGA coordinate to a grid cell and reads that cell's state from an external board store.
- Selects a tile bitmap from an external tile ROM bank, overlays a cursor border, and emits registered 4-bit RGB.
- Sits between the VGA timing generator and the game FSM. Grid size, origin, tile size and cursor style are parameters; the ROM/store are accessed through registered address/data ports instead of 13 parallel ROMs and a mux.

---
 rtl/tile_grid_renderer_if.sv | 27 ++
 rtl/tile_grid_renderer.sv | 195 +++++++++++++++++++
 tb/tb_tile_grid_renderer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/tile_grid_renderer_if.sv
// Board-store and tile-ROM bus of the tile grid renderer.
// The renderer drives registered addresses; memories return data one cycle later.
interface tile_grid_renderer_if #(
    parameter int GRID_W    = 16,
    parameter int GRID_H    = 16,
    parameter int STATE_W   = 4,
    parameter int TILE_LOG2 = 5
);
    logic [$clog2(GRID_W*GRID_H)-1:0] cell_addr_o;
    logic [STATE_W-1:0]               cell_state_i;
    logic [4+2*TILE_LOG2-1:0]         tile_addr_o;
    logic [11:0]                      tile_word_i;

    modport master (
        output cell_addr_o,
        input  cell_state_i,
        output tile_addr_o,
        input  tile_word_i
    );

    modport slave (
        input  cell_addr_o,
        output cell_state_i,
        input  tile_addr_o,
        output tile_word_i
    );
endinterface

// File: rtl/tile_grid_renderer.sv
// Three-register pixel pipeline: VGA coordinate -> board cell -> tile bitmap -> RGB with cursor overlay.
// Optional build macro CURSOR_BLINK_EN adds a frame counter that blinks the cursor.
module tile_grid_renderer #(
    parameter int   H_ACTIVE     = 800,
    parameter int   V_ACTIVE     = 600,
    parameter int   TILE_LOG2    = 5,
    parameter int   GRID_W       = 16,
    parameter int   GRID_H       = 16,
    parameter int   ORIGIN_H     = 144,
    parameter int   ORIGIN_V     = 44,
    parameter int   STATE_W      = 4,
    parameter int   BORDER       = 2,
    parameter logic [11:0] CURSOR_RGB = 12'hF00,
    parameter int   BLINK_FRAMES = 30
) (
    input  logic                      pixel_clk,
    input  logic                      rst_n,
    input  logic [10:0]               h_coord,
    input  logic [9:0]                v_coord,
    input  logic [$clog2(GRID_W)-1:0] cursor_x_i,
    input  logic [$clog2(GRID_H)-1:0] cursor_y_i,
    input  logic [11:0]               bg_rgb_i,
    tile_grid_renderer_if.master      mem,
    output logic [3:0]                red,
    output logic [3:0]                green,
    output logic [3:0]                blue,
    output logic                      frame_end_o
);
    localparam int TILE   = 1 << TILE_LOG2;
    localparam int CX_W   = $clog2(GRID_W);
    localparam int CY_W   = $clog2(GRID_H);
    localparam int ADDR_W = $clog2(GRID_W*GRID_H);
    localparam int TA_W   = 4 + 2*TILE_LOG2;

    // Cursor position, latched once per frame
    logic [CX_W-1:0] cur_x_reg;
    logic [CY_W-1:0] cur_y_reg;
    logic            cursor_visible;

    // S0: coordinate decode
    logic [11:0]          h_off, v_off;
    logic [CX_W-1:0]      cx;
    logic [CY_W-1:0]      cy;
    logic [TILE_LOG2-1:0] px_next, py_next;
    logic                 active_next, in_grid_next, border_next, hit_next, frame_end_next;
    logic [ADDR_W-1:0]    cell_addr_next;

    // Offsets wrap to large values below the origin, so one unsigned compare rejects both sides
    assign h_off   = {1'b0, h_coord} - 12'(ORIGIN_H);
    assign v_off   = {2'b0, v_coord} - 12'(ORIGIN_V);
    assign cx      = h_off[TILE_LOG2 +: CX_W];
    assign cy      = v_off[TILE_LOG2 +: CY_W];
    assign px_next = h_off[TILE_LOG2-1:0];
    assign py_next = v_off[TILE_LOG2-1:0];

    always_comb begin
        active_next    = (h_coord < 11'(H_ACTIVE)) && (v_coord < 10'(V_ACTIVE));
        in_grid_next   = active_next
                       && (h_off < 12'(GRID_W << TILE_LOG2))
                       && (v_off < 12'(GRID_H << TILE_LOG2));
        border_next    = (int'(px_next) < BORDER) || (int'(px_next) >= TILE - BORDER)
                      || (int'(py_next) < BORDER) || (int'(py_next) >= TILE - BORDER);
        hit_next       = in_grid_next && border_next
                       && (cx == cur_x_reg) && (cy == cur_y_reg)
                       && (int'(cur_x_reg) < GRID_W) && (int'(cur_y_reg) < GRID_H);
        frame_end_next = (h_coord == 11'(H_ACTIVE-1)) && (v_coord == 10'(V_ACTIVE-1));
        cell_addr_next = '0;
        if (in_grid_next) begin
            cell_addr_next = ADDR_W'(cy) * ADDR_W'(GRID_W) + ADDR_W'(cx);
        end
    end

    logic                 p1_active_reg, p1_in_grid_reg, p1_hit_reg;
    logic [TILE_LOG2-1:0] p1_px_reg, p1_py_reg;
    logic [11:0]          p1_bg_reg;

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            p1_active_reg   <= 1'b0;
            p1_in_grid_reg  <= 1'b0;
            p1_hit_reg      <= 1'b0;
            p1_px_reg       <= '0;
            p1_py_reg       <= '0;
            p1_bg_reg       <= '0;
            mem.cell_addr_o <= '0;
            frame_end_o     <= 1'b0;
        end else begin
            p1_active_reg   <= active_next;
            p1_in_grid_reg  <= in_grid_next;
            p1_hit_reg      <= hit_next;
            p1_px_reg       <= px_next;
            p1_py_reg       <= py_next;
            p1_bg_reg       <= bg_rgb_i;
            mem.cell_addr_o <= cell_addr_next;
            frame_end_o     <= frame_end_next;
        end
    end

    // S1: cell state -> tile bitmap index (all hidden variants share one bitmap)
    function automatic logic [3:0] tile_index(input logic [STATE_W-1:0] state);
        if (int'(state) <= 11) begin
            return 4'(state);
        end
        return 4'd12;
    endfunction

    logic [TA_W-1:0] tile_addr_next;
    logic            p2_active_reg, p2_in_grid_reg, p2_hit_reg;
    logic [11:0]     p2_bg_reg;

    always_comb begin
        tile_addr_next = '0;
        if (p1_in_grid_reg) begin
            tile_addr_next = {tile_index(mem.cell_state_i), p1_py_reg, p1_px_reg};
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            p2_active_reg   <= 1'b0;
            p2_in_grid_reg  <= 1'b0;
            p2_hit_reg      <= 1'b0;
            p2_bg_reg       <= '0;
            mem.tile_addr_o <= '0;
        end else begin
            p2_active_reg   <= p1_active_reg;
            p2_in_grid_reg  <= p1_in_grid_reg;
            p2_hit_reg      <= p1_hit_reg;
            p2_bg_reg       <= p1_bg_reg;
            mem.tile_addr_o <= tile_addr_next;
        end
    end

    // S3: colour selection
    logic [11:0] rgb_next, rgb_reg;

    always_comb begin
        rgb_next = mem.tile_word_i;
        if (!p2_active_reg) begin
            rgb_next = '0;
        end else if (!p2_in_grid_reg) begin
            rgb_next = p2_bg_reg;
        end else if (p2_hit_reg && cursor_visible) begin
            rgb_next = CURSOR_RGB;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            rgb_reg <= '0;
        end else begin
            rgb_reg <= rgb_next;
        end
    end

    assign red   = rgb_reg[3:0];
    assign green = rgb_reg[7:4];
    assign blue  = rgb_reg[11:8];

    // Cursor moves only at frame boundaries so a frame never shows two positions
    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            cur_x_reg <= '0;
            cur_y_reg <= '0;
        end else if (frame_end_o) begin
            cur_x_reg <= cursor_x_i;
            cur_y_reg <= cursor_y_i;
        end
    end

`ifdef CURSOR_BLINK_EN
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    logic [BW-1:0] blink_cnt_reg;
    logic          cursor_visible_reg;

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            blink_cnt_reg      <= '0;
            cursor_visible_reg <= 1'b1;
        end else if (frame_end_o) begin
            if (blink_cnt_reg == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_reg      <= '0;
                cursor_visible_reg <= ~cursor_visible_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + 1'b1;
            end
        end
    end

    assign cursor_visible = cursor_visible_reg;
`else
    assign cursor_visible = 1'b1;
`endif

endmodule

// File: tb/tb_tile_grid_renderer.sv
// Directed bench for tile_grid_renderer: reset, decode, background, cursor latching, tile mapping, blink.
module tb_tile_grid_renderer;
    localparam int TB_BLINK = 2;

    logic        pixel_clk = 1'b0;
    logic        rst_n;
    logic [10:0] h_coord;
    logic [9:0]  v_coord;
    logic [3:0]  cursor_x_i, cursor_y_i;
    logic [11:0] bg_rgb_i;
    logic [3:0]  red, green, blue;
    logic        frame_end_o;

    int checks = 0;
    int errors = 0;
    int tb_frames = 0;

    tile_grid_renderer_if #(.GRID_W(16), .GRID_H(16), .STATE_W(4), .TILE_LOG2(5)) mem_if ();

    tile_grid_renderer #(.BLINK_FRAMES(TB_BLINK)) dut (
        .pixel_clk   (pixel_clk),
        .rst_n       (rst_n),
        .h_coord     (h_coord),
        .v_coord     (v_coord),
        .cursor_x_i  (cursor_x_i),
        .cursor_y_i  (cursor_y_i),
        .bg_rgb_i    (bg_rgb_i),
        .mem         (mem_if.master),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .frame_end_o (frame_end_o)
    );

    always #5 pixel_clk = ~pixel_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rgb(input string tag, input logic [11:0] exp);
        check(tag, {20'b0, blue, green, red}, {20'b0, exp});
    endtask

    // Present a coordinate and hold it until its colour has reached the outputs
    task automatic hold(input int h, input int v);
        @(negedge pixel_clk);
        h_coord = 11'(h);
        v_coord = 10'(v);
        repeat (3) @(negedge pixel_clk);
    endtask

    // Present the last active pixel for exactly one cycle
    task automatic frame_pulse();
        @(negedge pixel_clk);
        h_coord = 11'd799;
        v_coord = 10'd599;
        @(negedge pixel_clk);
        check("frame_end_high", {31'b0, frame_end_o}, 32'd1);
        h_coord = 11'd0;
        v_coord = 10'd0;
        @(negedge pixel_clk);
        check("frame_end_low", {31'b0, frame_end_o}, 32'd0);
        tb_frames++;
    endtask

    function automatic bit vis_now();
`ifdef CURSOR_BLINK_EN
        return ((tb_frames / TB_BLINK) % 2) == 0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [11:0] cursor_exp();
        return vis_now() ? 12'hF00 : 12'h5A3;
    endfunction

    logic [4:0] blink_pattern;

    initial begin
`ifdef CURSOR_BLINK_EN
        blink_pattern = 5'b10011;
`else
        blink_pattern = 5'b11111;
`endif
        rst_n = 1'b0;
        h_coord = 11'd0;
        v_coord = 10'd0;
        cursor_x_i = 4'd0;
        cursor_y_i = 4'd0;
        bg_rgb_i = 12'h000;
        mem_if.cell_state_i = 4'd3;
        mem_if.tile_word_i = 12'h5A3;
        repeat (4) @(negedge pixel_clk);
        check_rgb("reset_rgb", 12'h000);
        check("reset_frame_end", {31'b0, frame_end_o}, 32'd0);
        check("reset_cell_addr", 32'(mem_if.cell_addr_o), 32'd0);
        check("reset_tile_addr", 32'(mem_if.tile_addr_o), 32'd0);
        rst_n = 1'b1;

        hold(0, 0);
        check_rgb("origin_screen_rgb", 12'h000);
        check("origin_screen_frame_end", {31'b0, frame_end_o}, 32'd0);
        check("origin_screen_cell_addr", 32'(mem_if.cell_addr_o), 32'd0);

        // After reset the cursor sits on cell (0,0)
        hold(144, 44);
        check("cell00_tile_addr", 32'(mem_if.tile_addr_o), 32'h0C00);
        check_rgb("cell00_reset_cursor", 12'hF00);

        cursor_x_i = 4'd2;
        cursor_y_i = 4'd1;
        frame_pulse();
        hold(144, 44);
        check("cell00_cell_addr", 32'(mem_if.cell_addr_o), 32'd0);
        check("cell00_tile_addr2", 32'(mem_if.tile_addr_o), 32'h0C00);
        check_rgb("cell00_tile_rgb", 12'h5A3);

        bg_rgb_i = 12'h008;
        hold(100, 300);
        check_rgb("left_bg", 12'h008);
        hold(810, 300);
        check_rgb("h_blank", 12'h000);
        hold(100, 600);
        check_rgb("v_blank", 12'h000);
        hold(143, 44);
        check_rgb("left_of_origin", 12'h008);
        hold(144, 43);
        check_rgb("above_origin", 12'h008);
        hold(655, 44);
        check("right_edge_cell_addr", 32'(mem_if.cell_addr_o), 32'd15);
        check("right_edge_tile_addr", 32'(mem_if.tile_addr_o), 32'h0C1F);
        check_rgb("right_edge_rgb", 12'h5A3);
        hold(656, 44);
        check_rgb("right_of_grid", 12'h008);
        hold(144, 555);
        check("bottom_edge_cell_addr", 32'(mem_if.cell_addr_o), 32'd240);
        check_rgb("bottom_edge_rgb", 12'h5A3);
        hold(144, 556);
        check_rgb("below_grid", 12'h008);

        // Cursor latched at (2,1)
        hold(209, 86);
        check("cursor_cell_addr", 32'(mem_if.cell_addr_o), 32'd18);
        check_rgb("cursor_px1", cursor_exp());
        hold(210, 86);
        check_rgb("cursor_px2_inside", 12'h5A3);
        hold(218, 86);
        check_rgb("cursor_px10_py10", 12'h5A3);
        hold(218, 107);
        check_rgb("cursor_py31", cursor_exp());
        hold(238, 86);
        check_rgb("cursor_px30", cursor_exp());
        hold(237, 86);
        check_rgb("cursor_px29", 12'h5A3);

        cursor_x_i = 4'd0;
        cursor_y_i = 4'd0;
        hold(209, 86);
        check_rgb("midframe_old_cursor", cursor_exp());
        hold(145, 45);
        check_rgb("midframe_new_unseen", 12'h5A3);
        frame_pulse();
        hold(145, 45);
        check_rgb("newframe_new_cursor", cursor_exp());
        hold(209, 86);
        check_rgb("newframe_old_gone", 12'h5A3);

        // Cell-state to tile-index mapping at cell (1,1)
        mem_if.cell_state_i = 4'd14;
        hold(176, 76);
        check("map14_cell_addr", 32'(mem_if.cell_addr_o), 32'd17);
        check("map14_tile_addr", 32'(mem_if.tile_addr_o), 32'h3000);
        mem_if.cell_state_i = 4'd9;
        hold(176, 76);
        check("map9_tile_addr", 32'(mem_if.tile_addr_o), 32'h2400);
        mem_if.cell_state_i = 4'd10;
        hold(176, 76);
        check("map10_tile_addr", 32'(mem_if.tile_addr_o), 32'h2800);
        mem_if.cell_state_i = 4'd11;
        hold(176, 76);
        check("map11_tile_addr", 32'(mem_if.tile_addr_o), 32'h2C00);
        mem_if.cell_state_i = 4'd12;
        hold(176, 76);
        check("map12_tile_addr", 32'(mem_if.tile_addr_o), 32'h3000);
        mem_if.cell_state_i = 4'd0;
        hold(176, 76);
        check("map0_tile_addr", 32'(mem_if.tile_addr_o), 32'h0000);

        // Reset asserted mid-line
        mem_if.cell_state_i = 4'd3;
        hold(218, 86);
        check_rgb("pre_reset_rgb", 12'h5A3);
        rst_n = 1'b0;
        @(negedge pixel_clk);
        check_rgb("midline_reset_rgb", 12'h000);
        check("midline_reset_cell_addr", 32'(mem_if.cell_addr_o), 32'd0);
        h_coord = 11'd145;
        v_coord = 10'd45;
        @(negedge pixel_clk);
        rst_n = 1'b1;
        tb_frames = 0;
        @(negedge pixel_clk);
        check_rgb("post_reset_cycle1", 12'h000);
        @(negedge pixel_clk);
        check_rgb("post_reset_cycle2", 12'h000);
        @(negedge pixel_clk);
        check_rgb("post_reset_cursor_visible", 12'hF00);

        for (int f = 0; f < 5; f++) begin
            hold(145, 45);
            check_rgb($sformatf("blink_frame%0d", f), blink_pattern[f] ? 12'hF00 : 12'h5A3);
            if (f < 4) begin
                frame_pulse();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
